// File: rtl/polyshift_pkg.sv
// Shared types and helpers for the polyshift shifter pipeline.
// Optional zero flag: define POLYSHIFT_ZF_EN.
package polyshift_pkg;

    typedef enum logic [2:0] {
        LSR = 3'd0,
        ASR = 3'd1,
        ROR = 3'd2,
        RCR = 3'd3,
        LSL = 3'd4,
        ROL = 3'd5,
        RCL = 3'd6,
        RSV = 3'd7
    } shift_mode_t;

    function automatic logic is_left(shift_mode_t m);
        return (m == LSL) || (m == ROL) || (m == RCL);
    endfunction

    // Right-shift equivalent of a mode once the operand is bit-reversed.
    function automatic shift_mode_t to_right(shift_mode_t m);
        shift_mode_t r;
        r = m;
        unique case (m)
            LSL:     r = LSR;
            ROL:     r = ROR;
            RCL:     r = RCR;
            default: r = m;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/polyshift_if.sv
// Operation / result handshake bundle for polyshift_pipe.
// zf_o is present only with POLYSHIFT_ZF_EN.
interface polyshift_if #(
    parameter int WORD_WIDTH = 8
);
    import polyshift_pkg::*;

    logic                          valid_i;
    logic                          ready_o;
    shift_mode_t                   mode_i;
    logic [$clog2(WORD_WIDTH)-1:0] shift_size_i;
    logic [WORD_WIDTH-1:0]         data_i;
    logic                          cf_i;
    logic                          valid_o;
    logic                          ready_i;
    logic [WORD_WIDTH-1:0]         data_o;
    logic                          cf_o;
`ifdef POLYSHIFT_ZF_EN
    logic                          zf_o;
`endif

    modport slave (
        input  valid_i,
        output ready_o,
        input  mode_i,
        input  shift_size_i,
        input  data_i,
        input  cf_i,
        output valid_o,
        input  ready_i,
        output data_o,
        output cf_o
`ifdef POLYSHIFT_ZF_EN
        ,
        output zf_o
`endif
    );

    modport master (
        output valid_i,
        input  ready_o,
        output mode_i,
        output shift_size_i,
        output data_i,
        output cf_i,
        input  valid_o,
        output ready_i,
        input  data_o,
        input  cf_o
`ifdef POLYSHIFT_ZF_EN
        ,
        input  zf_o
`endif
    );

endinterface

// File: rtl/polyshift_core.sv
// Combinational multi-mode shifter with carry-out.
// Left modes reuse the right shifter on a bit-reversed operand.
module polyshift_core
    import polyshift_pkg::*;
#(
    parameter int W = 8
) (
    input  shift_mode_t          mode_i,
    input  logic [$clog2(W)-1:0] size_i,
    input  logic [W-1:0]         data_i,
    input  logic                 cf_i,
    output logic [W-1:0]         data_o,
    output logic                 cf_o
);
    localparam int SW = $clog2(W);

    logic              left;
    shift_mode_t       rmode;
    logic [W-1:0]      din;
    logic [2*W-1:0]    wide;
    logic [W-1:0]      rres;
    logic [W-1:0]      rres_rev;

    assign left  = is_left(mode_i);
    assign rmode = to_right(mode_i);

    // Operand as seen by the right shifter
    always_comb begin
        din = data_i;
        if (left) begin
            for (int i = 0; i < W; i++) din[i] = data_i[W-1-i];
        end
    end

    // Right shift with mode-dependent fill; RCR rotates the W+1 bit {cf,data}
    always_comb begin
        wide = {{W{1'b0}}, din};
        rres = '0;
        unique case (rmode)
            ASR:     wide = {{W{din[W-1]}}, din};
            ROR:     wide = {din, din};
            default: wide = {{W{1'b0}}, din};
        endcase
        if (rmode == RCR)
            rres = W'({cf_i, din, cf_i, din} >> size_i);
        else
            rres = W'(wide >> size_i);
    end

    // Undo the operand reversal for left modes
    always_comb begin
        rres_rev = rres;
        for (int i = 0; i < W; i++) rres_rev[i] = rres[W-1-i];
    end

    // Select final result; zero shift and reserved mode pass through
    always_comb begin
        data_o = data_i;
        cf_o   = cf_i;
        if (mode_i != RSV && size_i != '0) begin
            data_o = left ? rres_rev : rres;
            cf_o   = din[size_i - SW'(1)];
        end
    end

endmodule

// File: rtl/polyshift_pipe.sv
// Two-stage shifter pipeline with valid/ready handshakes.
// Define POLYSHIFT_ZF_EN to add the registered zero flag.
module polyshift_pipe
    import polyshift_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input logic       clk_i,
    input logic       rst_i,
    polyshift_if.slave bus
);
    localparam int W  = WORD_WIDTH;
    localparam int SW = $clog2(W);

    logic           s1_valid;
    logic           s2_valid;
    logic           s1_adv;
    logic           s2_adv;
    shift_mode_t    s1_mode;
    logic [SW-1:0]  s1_size;
    logic [W-1:0]   s1_data;
    logic           s1_cf;
    logic [W-1:0]   core_data;
    logic           core_cf;
    logic [W-1:0]   s2_data;
    logic           s2_cf;

    assign s2_adv      = !s2_valid || bus.ready_i;
    assign s1_adv      = !s1_valid || s2_adv;
    assign bus.ready_o = s1_adv;
    assign bus.valid_o = s2_valid;
    assign bus.data_o  = s2_data;
    assign bus.cf_o    = s2_cf;

    polyshift_core #(.W(W)) u_core (
        .mode_i (s1_mode),
        .size_i (s1_size),
        .data_i (s1_data),
        .cf_i   (s1_cf),
        .data_o (core_data),
        .cf_o   (core_cf)
    );

    // S1: capture operation on accept
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_mode  <= LSR;
            s1_size  <= '0;
            s1_data  <= '0;
            s1_cf    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.valid_i;
            if (bus.valid_i) begin
                s1_mode <= bus.mode_i;
                s1_size <= bus.shift_size_i;
                s1_data <= bus.data_i;
                s1_cf   <= bus.cf_i;
            end
        end
    end

    // S2: register computed result, held while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_cf    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= core_data;
                s2_cf   <= core_cf;
            end
        end
    end

`ifdef POLYSHIFT_ZF_EN
    logic s2_zf;

    assign bus.zf_o = s2_zf;

    // S2 zero flag tracks the registered result word only
    always_ff @(posedge clk_i) begin
        if (rst_i)
            s2_zf <= 1'b0;
        else if (s2_adv && s1_valid)
            s2_zf <= (core_data == '0);
    end
`endif

endmodule

// File: tb/tb_polyshift_pipe.sv
// Self-checking bench for polyshift_pipe (WORD_WIDTH=8).
// Reference model: arithmetic shift rules plus an in-flight result queue.
module tb_polyshift_pipe;
    import polyshift_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    polyshift_if #(.WORD_WIDTH(W)) bus ();

    polyshift_pipe #(.WORD_WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        int           age;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {cf, data}
    function automatic logic [W:0] ref_op(input int m, input int n,
                                          input logic [W-1:0] d,
                                          input logic c);
        logic [W-1:0]        r;
        logic [W:0]          v;
        logic signed [W-1:0] s;
        logic                co;
        if (n == 0 || m == 7) return {c, d};
        r = d;
        case (m)
            0: r = d >> n;
            1: begin s = d; s = s >>> n; r = s; end
            2: r = (d >> n) | (d << (W - n));
            3: begin
                v = {c, d};
                v = (v >> n) | (v << (W + 1 - n));
                r = v[W-1:0];
            end
            4: r = d << n;
            5: r = (d << n) | (d >> (W - n));
            6: begin
                v = {d, c};
                v = (v << n) | (v >> (W + 1 - n));
                r = v[W:1];
            end
            default: r = d;
        endcase
        co = (m < 4) ? d[n-1] : d[W-n];
        return {co, r};
    endfunction

    // One cycle; entered and left at a falling edge
    task automatic step(input logic v, input int m, input int n,
                        input logic [W-1:0] d, input logic c,
                        input logic rdy);
        logic       expv;
        logic       exprdy;
        logic       acc;
        logic       drn;
        logic [W:0] r;
        exp_t       e;
        bus.valid_i      = v;
        bus.mode_i       = shift_mode_t'(3'(m));
        bus.shift_size_i = 3'(n);
        bus.data_i       = d;
        bus.cf_i         = c;
        bus.ready_i      = rdy;
        #1;
        exprdy = rdy || (q.size() < 2);
        expv   = (q.size() > 0) && (q[0].age >= 1);
        chk("ready_o", 32'(bus.ready_o), 32'(exprdy));
        chk("valid_o", 32'(bus.valid_o), 32'(expv));
        if (expv) begin
            chk("data_o", 32'(bus.data_o), 32'(q[0].d));
            chk("cf_o", 32'(bus.cf_o), 32'(q[0].c));
`ifdef POLYSHIFT_ZF_EN
            chk("zf_o", 32'(bus.zf_o), 32'(q[0].d == '0));
`endif
        end
        acc = v && exprdy;
        drn = expv && rdy;
        @(posedge clk);
        if (drn) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (acc) begin
            r     = ref_op(m, n, d, c);
            e.d   = r[W-1:0];
            e.c   = r[W];
            e.age = 0;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, '0, 1'b0, rdy);
    endtask

    task automatic check_reset_state();
        chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
        chk("rst_data_o", 32'(bus.data_o), 32'd0);
        chk("rst_cf_o", 32'(bus.cf_o), 32'd0);
        chk("rst_ready_o", 32'(bus.ready_o), 32'd1);
`ifdef POLYSHIFT_ZF_EN
        chk("rst_zf_o", 32'(bus.zf_o), 32'd0);
`endif
    endtask

    initial begin
        bus.valid_i      = 1'b0;
        bus.mode_i       = LSR;
        bus.shift_size_i = '0;
        bus.data_i       = '0;
        bus.cf_i         = 1'b0;
        bus.ready_i      = 1'b0;
        rst              = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        @(negedge clk);

        // Directed single operations, each drained with latency checked
        step(1'b1, 0, 3, 8'hB5, 1'b0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 1, 2, 8'h84, 1'b0, 1'b1);
        step(1'b1, 3, 1, 8'h01, 1'b1, 1'b1);
        step(1'b1, 4, 1, 8'h81, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Zero shift in every mode
        for (int m = 0; m < 8; m++) step(1'b1, m, 0, 8'h5A, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Back-to-back stream of 16 operations
        for (int i = 0; i < 16; i++)
            step(1'b1, $urandom_range(7), $urandom_range(W - 1),
                 8'($urandom), 1'($urandom), 1'b1);
        idle(3, 1'b1);

        // Fill pipe, hold downstream for 5 cycles, then release
        step(1'b1, 2, 3, 8'hC3, 1'b0, 1'b0);
        step(1'b1, 5, 5, 8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b1, 6, 2, 8'hF0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 6, 7, 8'(i * 37), 1'b0, 1'b1);
        idle(3, 1'b1);

`ifdef POLYSHIFT_ZF_EN
        step(1'b1, 0, 4, 8'h0F, 1'b0, 1'b1);
        idle(3, 1'b1);
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++)
            step(1'($urandom), $urandom_range(7), $urandom_range(W - 1),
                 8'($urandom), 1'($urandom), ($urandom_range(3) != 0));
        idle(4, 1'b1);

        // Reset with both stages full
        step(1'b1, 0, 1, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 4, 1, 8'hFF, 1'b1, 1'b0);
        bus.valid_i = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state();
        q.delete();
        @(negedge clk);
        idle(3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
